bcd_counter_ndigit: RTL and testbench
=====================================

Name: bcd_counter_ndigit

Overview:
Parametrised multi-digit BCD counter. It is the successor to the fixed 14-bit binary 0-9999 counter. It counts directly in packed BCD, so the seven-segment path needs no binary-to-BCD conversion. Over the old block it adds:
- configurable digit count and modulus
- up/down direction
- parallel load with validation
- wrap or saturate mode
- clock-enable prescaler
- terminal-count and sticky overflow flags

It sits between the board switch/button debouncers and the seven-segment display driver.

Parameters:
NUM_DIGITS, 4, number of BCD digits; count width is 4*NUM_DIGITS bits.
MAX_VALUE, 9999, decimal upper bound of the count; must satisfy 1 <= MAX_VALUE <= 10^NUM_DIGITS - 1.
WRAP, 1, 1 = wrap at bounds; 0 = saturate at bounds.
TICK_DIV, 1, count steps once every TICK_DIV enabled clocks; must be >= 1.

Ports:
counter_clk_signal  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
switch  input  1  count enable; 0 holds the count and the prescaler.
button  input  1  synchronous clear of count, prescaler and overflow.
up_down  input  1  1 = count up, 0 = count down; sampled on each step.
load  input  1  synchronous parallel load request.
load_value  input  4*NUM_DIGITS  packed BCD load value; digit 0 is in bits [3:0].
bcd_count  output  4*NUM_DIGITS  packed BCD count; digit 0 is the LSD.
terminal_count  output  1  one-cycle pulse on a bound event.
overflow  output  1  sticky flag set by any bound event.
load_error  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock domain, counter_clk_signal.
- reset_n low (asynchronous, active-low):
  - bcd_count = 0, prescaler = 0
  - terminal_count, overflow, load_error = 0
  - takes effect immediately, independent of the clock, including mid-count.
- Per-edge priority, highest first: button > load > count step.
- button = 1:
  - bcd_count, prescaler and overflow all cleared to 0
  - load and switch are ignored that cycle
  - terminal_count and load_error are 0 the next cycle.
- load = 1 with button = 0:
  - Validity: every digit of load_value is <= 9 and the value is <= MAX_VALUE.
  - Valid load: bcd_count <= load_value and prescaler cleared.
  - Invalid load: bcd_count unchanged, prescaler unchanged, load_error pulses high for exactly one cycle.
  - Either way, no count step occurs that cycle.
- Prescaler:
  - Internal counter runs 0..TICK_DIV-1 and advances only when switch = 1 with no clear and no load.
  - A step is generated on the edge where the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - TICK_DIV = 1 gives a step on every enabled clock.
  - switch = 0 freezes both the prescaler and the count.
- Step, up:
  - Digit-serial BCD increment: a digit at 9 becomes 0 and carries into the next digit.
  - If bcd_count == MAX_VALUE: WRAP = 1 loads 0; WRAP = 0 holds MAX_VALUE.
- Step, down:
  - Digit-serial BCD decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - If bcd_count == 0: WRAP = 1 loads MAX_VALUE; WRAP = 0 holds 0.
- Bound event: a step taken while at the bound in the current direction.
  - terminal_count is registered high for exactly the cycle after that edge, aligned with the updated bcd_count.
  - overflow is set on the same edge and stays set until button or reset_n.
  - In saturate mode, every step attempted at the bound re-pulses terminal_count.
- Arithmetic and invariants:
  - bcd_count never holds a non-BCD digit and never exceeds MAX_VALUE.
  - MAX_VALUE is converted to BCD at elaboration.
  - The comparison is a full-width equality on the packed BCD value.
  - No binary intermediate is used.
- Direction change: up_down may toggle on any cycle and takes effect on the next step. No pipeline is involved; latency is one edge from step to the updated output.
- All outputs are registered.

Test Plan:
- Reset: assert reset_n = 0 mid-count at 0x1234 without a clock edge -> bcd_count = 0x0000 and all flags 0 immediately.
- Up-wrap: defaults; load 0x9998; switch = 1, up_down = 1, 3 clocks -> 0x9999, 0x0000, 0x0001; terminal_count high only with 0x0000; overflow stays 1.
- Down-saturate: WRAP = 0, MAX_VALUE = 59, NUM_DIGITS = 2; load 0x01; down 3 steps -> 0x00, 0x00, 0x00; terminal_count pulses on the 2nd and 3rd steps.
- Load checks: load 0x12A4 -> load_error pulses 1 cycle and count is unchanged. With MAX_VALUE = 5000, load 0x6000 -> rejected. Load 0x0450 -> accepted, bcd_count = 0x0450.
- Prescaler: TICK_DIV = 3, up from 0x0000 for 9 enabled clocks with switch dropped for 2 clocks midway -> count reaches 0x0003 only after 9 enabled clocks; frozen while switch = 0.
- Priority: button = 1 and load = 1 together with switch = 1 and overflow set -> bcd_count = 0, overflow = 0, no load_error.

Source files
------------

// File: rtl/bcd_counter_ndigit.sv
`default_nettype none
// ==== bcd_counter_ndigit : N-digit packed-BCD up/down counter with load, prescaler, flags ====
// ==== Rev 1.0 ====

module bcd_counter_ndigit #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_VALUE  = 9999,
    parameter int WRAP       = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                    counter_clk_signal,
    input  logic                    reset_n,
    input  logic                    switch,
    input  logic                    button,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd_count,
    output logic                    terminal_count,
    output logic                    overflow,
    output logic                    load_error
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [W-1:0] dec_to_bcd(input int value);
        logic [W-1:0] res;
        int           rem;
        res = '0;
        rem = value;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            res[4*k +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    localparam logic [W-1:0]  MAX_BCD  = dec_to_bcd(MAX_VALUE);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0]         prescaler;
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] borrow;
    logic [NUM_DIGITS-1:0] digit_ok;
    logic [W-1:0]          inc_value;
    logic [W-1:0]          dec_value;
    logic [W-1:0]          bound_value;
    logic                  step;
    logic                  load_ok;
    logic                  at_bound;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Ripple carry/borrow digit by digit; a digit changes only when every lower digit rolled over.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] digit;
        assign digit = bcd_count[4*i +: 4];
        assign inc_value[4*i +: 4] = carry[i]  ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
        assign dec_value[4*i +: 4] = borrow[i] ? ((digit == 4'd0) ? 4'd9 : digit - 4'd1) : digit;
        assign digit_ok[i] = (load_value[4*i +: 4] <= 4'd9);
        if (i < NUM_DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  & (digit == 4'd9);
            assign borrow[i+1] = borrow[i] & (digit == 4'd0);
        end
    end

    // Packed BCD orders like its decimal value once all digits are legal.
    assign load_ok     = (&digit_ok) && (load_value <= MAX_BCD);
    assign step        = switch && (prescaler == PRE_LAST);
    assign at_bound    = up_down ? (bcd_count == MAX_BCD) : (bcd_count == {W{1'b0}});
    assign bound_value = (WRAP != 0) ? (up_down ? {W{1'b0}} : MAX_BCD)
                                     : (up_down ? MAX_BCD : {W{1'b0}});

    always_ff @(posedge counter_clk_signal or negedge reset_n) begin
        if (!reset_n) begin
            bcd_count      <= '0;
            prescaler      <= '0;
            terminal_count <= 1'b0;
            overflow       <= 1'b0;
            load_error     <= 1'b0;
        end else if (button) begin
            bcd_count      <= '0;
            prescaler      <= '0;
            terminal_count <= 1'b0;
            overflow       <= 1'b0;
            load_error     <= 1'b0;
        end else if (load) begin
            terminal_count <= 1'b0;
            if (load_ok) begin
                bcd_count  <= load_value;
                prescaler  <= '0;
                load_error <= 1'b0;
            end else begin
                load_error <= 1'b1;
            end
        end else begin
            terminal_count <= 1'b0;
            load_error     <= 1'b0;
            if (switch) begin
                if (step) begin
                    prescaler <= '0;
                    if (at_bound) begin
                        bcd_count      <= bound_value;
                        terminal_count <= 1'b1;
                        overflow       <= 1'b1;
                    end else begin
                        bcd_count <= up_down ? inc_value : dec_value;
                    end
                end else begin
                    prescaler <= prescaler + PRE_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_ndigit.sv
`default_nettype none
// ==== tb_bcd_counter_ndigit : three parameterisations against a decimal reference model ====
// ==== Rev 1.0 ====

module tb_bcd_counter_ndigit;

    localparam int ND   [3] = '{4, 2, 4};
    localparam int MAXV [3] = '{9999, 59, 5000};
    localparam int WR   [3] = '{1, 0, 1};
    localparam int DIV  [3] = '{1, 1, 3};

    logic        clk;
    logic        reset_n;
    logic        switch;
    logic        button;
    logic        up_down;
    logic        load;
    logic [15:0] lv [3];

    logic [15:0] cnt_a, cnt_c;
    logic [7:0]  cnt_b;
    logic        tc_a, tc_b, tc_c, ov_a, ov_b, ov_c, le_a, le_b, le_c;

    int tests;
    int failures;
    bit check_en;

    int cnt [3];
    int pre [3];
    bit m_tc [3];
    bit m_ov [3];
    bit m_le [3];

    bcd_counter_ndigit #(.NUM_DIGITS(4), .MAX_VALUE(9999), .WRAP(1), .TICK_DIV(1)) dut_a (
        .counter_clk_signal(clk), .reset_n(reset_n), .switch(switch), .button(button),
        .up_down(up_down), .load(load), .load_value(lv[0]), .bcd_count(cnt_a),
        .terminal_count(tc_a), .overflow(ov_a), .load_error(le_a));

    bcd_counter_ndigit #(.NUM_DIGITS(2), .MAX_VALUE(59), .WRAP(0), .TICK_DIV(1)) dut_b (
        .counter_clk_signal(clk), .reset_n(reset_n), .switch(switch), .button(button),
        .up_down(up_down), .load(load), .load_value(lv[1][7:0]), .bcd_count(cnt_b),
        .terminal_count(tc_b), .overflow(ov_b), .load_error(le_b));

    bcd_counter_ndigit #(.NUM_DIGITS(4), .MAX_VALUE(5000), .WRAP(1), .TICK_DIV(3)) dut_c (
        .counter_clk_signal(clk), .reset_n(reset_n), .switch(switch), .button(button),
        .up_down(up_down), .load(load), .load_value(lv[2]), .bcd_count(cnt_c),
        .terminal_count(tc_c), .overflow(ov_c), .load_error(le_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal value of a load request, or -1 when the counter must reject it.
    function automatic int lv_dec(input int i, input logic [15:0] v);
        int r;
        int m;
        r = 0;
        m = 1;
        for (int k = 0; k < ND[i]; k++) begin
            if (v[4*k +: 4] > 4'd9) return -1;
            r = r + int'(v[4*k +: 4]) * m;
            m = m * 10;
        end
        if (r > MAXV[i]) return -1;
        return r;
    endfunction

    function automatic logic [15:0] dut_cnt(input int i);
        case (i)
            0:       return cnt_a;
            1:       return {8'h00, cnt_b};
            default: return cnt_c;
        endcase
    endfunction

    function automatic logic [2:0] dut_flags(input int i);
        case (i)
            0:       return {tc_a, ov_a, le_a};
            1:       return {tc_b, ov_b, le_b};
            default: return {tc_c, ov_c, le_c};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                cnt[i] <= 0; pre[i] <= 0; m_tc[i] <= 0; m_ov[i] <= 0; m_le[i] <= 0;
            end else if (button) begin
                cnt[i] <= 0; pre[i] <= 0; m_tc[i] <= 0; m_ov[i] <= 0; m_le[i] <= 0;
            end else if (load) begin
                m_tc[i] <= 0;
                if (lv_dec(i, lv[i]) >= 0) begin
                    cnt[i]  <= lv_dec(i, lv[i]);
                    pre[i]  <= 0;
                    m_le[i] <= 0;
                end else begin
                    m_le[i] <= 1;
                end
            end else begin
                m_tc[i] <= 0;
                m_le[i] <= 0;
                if (switch) begin
                    if (pre[i] == DIV[i] - 1) begin
                        pre[i] <= 0;
                        if (up_down ? (cnt[i] == MAXV[i]) : (cnt[i] == 0)) begin
                            m_tc[i] <= 1;
                            m_ov[i] <= 1;
                            if (WR[i] != 0) cnt[i] <= up_down ? 0 : MAXV[i];
                        end else begin
                            cnt[i] <= up_down ? cnt[i] + 1 : cnt[i] - 1;
                        end
                    end else begin
                        pre[i] <= pre[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_count[%0d]", i), {16'h0, dut_cnt(i)}, {16'h0, to_bcd(cnt[i])});
                check($sformatf("model_flags[%0d] tc/ov/le", i), {29'h0, dut_flags(i)},
                      {29'h0, m_tc[i], m_ov[i], m_le[i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_lv(input int i);
        logic [15:0] v;
        v = '0;
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
            2: v = to_bcd(MAXV[i]);
            default: v = to_bcd(MAXV[i] - int'($urandom_range(0, 3)));
        endcase
        return v;
    endfunction

    initial begin
        tests = 0; failures = 0; check_en = 0;
        switch = 0; button = 0; up_down = 1; load = 0;
        for (int i = 0; i < 3; i++) lv[i] = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
        check_en = 1;
        check("reset count a", {16'h0, cnt_a}, 32'h0);
        check("reset flags a", {29'h0, tc_a, ov_a, le_a}, 32'h0);

        // Up-wrap on the default 4-digit counter.
        load = 1; lv[0] = 16'h9998;
        tick();
        check("load 9998", {16'h0, cnt_a}, 32'h9998);
        load = 0; switch = 1; up_down = 1;
        tick();
        check("up 9999", {16'h0, cnt_a}, 32'h9999);
        check("up 9999 tc", {31'h0, tc_a}, 32'h0);
        tick();
        check("wrap 0000", {16'h0, cnt_a}, 32'h0000);
        check("wrap tc", {31'h0, tc_a}, 32'h1);
        check("wrap ov", {31'h0, ov_a}, 32'h1);
        tick();
        check("up 0001", {16'h0, cnt_a}, 32'h0001);
        check("up 0001 tc", {31'h0, tc_a}, 32'h0);
        check("ov sticky", {31'h0, ov_a}, 32'h1);

        // Down-saturate on the 2-digit 0..59 counter.
        switch = 0; load = 1; lv[1] = 16'h0001;
        tick();
        check("load b 01", {24'h0, cnt_b}, 32'h01);
        load = 0; switch = 1; up_down = 0;
        tick();
        check("down b 00", {24'h0, cnt_b}, 32'h00);
        check("down b tc1", {31'h0, tc_b}, 32'h0);
        tick();
        check("sat b 00", {24'h0, cnt_b}, 32'h00);
        check("sat b tc2", {31'h0, tc_b}, 32'h1);
        tick();
        check("sat b tc3", {31'h0, tc_b}, 32'h1);
        check("sat b ov", {31'h0, ov_b}, 32'h1);

        // Load validation on the 0..5000 counter.
        switch = 0; load = 1; lv[2] = 16'h0100;
        tick();
        check("load c 0100", {16'h0, cnt_c}, 32'h0100);
        lv[2] = 16'h12A4;
        tick();
        check("nonbcd keep", {16'h0, cnt_c}, 32'h0100);
        check("nonbcd err", {31'h0, le_c}, 32'h1);
        lv[2] = 16'h6000;
        tick();
        check("over max keep", {16'h0, cnt_c}, 32'h0100);
        check("over max err", {31'h0, le_c}, 32'h1);
        load = 0;
        tick();
        check("err pulse end", {31'h0, le_c}, 32'h0);
        load = 1; lv[2] = 16'h0450;
        tick();
        check("load c 0450", {16'h0, cnt_c}, 32'h0450);
        check("load c ok", {31'h0, le_c}, 32'h0);

        // Prescaler of 3 with switch dropped midway.
        load = 0; button = 1;
        tick();
        check("clear c", {16'h0, cnt_c}, 32'h0);
        button = 0; up_down = 1; switch = 1;
        repeat (4) tick();
        check("presc 4 clk", {16'h0, cnt_c}, 32'h0001);
        switch = 0;
        repeat (2) tick();
        check("presc frozen", {16'h0, cnt_c}, 32'h0001);
        switch = 1;
        repeat (4) tick();
        check("presc 8 clk", {16'h0, cnt_c}, 32'h0002);
        tick();
        check("presc 9 clk", {16'h0, cnt_c}, 32'h0003);

        // Button beats load and count.
        switch = 0; load = 1; lv[0] = 16'h9999;
        tick();
        load = 0; switch = 1;
        tick();
        check("prio ov set", {31'h0, ov_a}, 32'h1);
        button = 1; load = 1; lv[0] = 16'h1234;
        tick();
        check("prio count", {16'h0, cnt_a}, 32'h0);
        check("prio ov clr", {31'h0, ov_a}, 32'h0);
        lv[0] = 16'h12A4;
        tick();
        check("prio no err", {31'h0, le_a}, 32'h0);
        button = 0; load = 0;

        // Asynchronous reset between clock edges.
        switch = 0; load = 1; lv[0] = 16'h1234;
        tick();
        load = 0; switch = 1;
        check("pre-reset 1234", {16'h0, cnt_a}, 32'h1234);
        #2 reset_n = 1'b0;
        #1;
        check("async reset count", {16'h0, cnt_a}, 32'h0);
        check("async reset flags", {29'h0, tc_a, ov_a, le_a}, 32'h0);
        tick();
        reset_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            button = ($urandom_range(0, 99) < 2);
            load   = ($urandom_range(0, 99) < 8);
            switch = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 5) up_down = ~up_down;
            for (int i = 0; i < 3; i++) lv[i] = rand_lv(i);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

`default_nettype wire
